// File: rtl/heroe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : heroe_pkg
// Brief   : Hero/movement codes and sequencer state shared with the char ROM.
// Revision: 1.0 - initial release
// ============================================================================
package heroe_pkg;

  localparam logic [2:0] HERO_MIN = 3'd1;
  localparam logic [2:0] HERO_MAX = 3'd5;

  localparam logic [1:0] MOV_NONE    = 2'd0;
  localparam logic [1:0] MOV_VOLAR   = 2'd1;
  localparam logic [1:0] MOV_SALTAR  = 2'd2;
  localparam logic [1:0] MOV_AGACHAR = 2'd3;

  // Bit positions of the buttons inside the packed edge-detect vector
  localparam int BTN_NEXT    = 0;
  localparam int BTN_OK      = 1;
  localparam int BTN_VOLAR   = 2;
  localparam int BTN_SALTAR  = 3;
  localparam int BTN_AGACHAR = 4;
  localparam int BTN_W       = 5;

  typedef enum logic [1:0] {
    SEL  = 2'd0,
    IDLE = 2'd1,
    MOVE = 2'd2
  } state_t;

  function automatic logic [2:0] next_hero(input logic [2:0] h);
    return (h >= HERO_MAX) ? HERO_MIN : h + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/heroe_mov_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : heroe_mov_ctrl_if
// Brief   : Button inputs and ROM select outputs of the movement sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface heroe_mov_ctrl_if;

  logic       btn_next;
  logic       btn_ok;
  logic       btn_volar;
  logic       btn_saltar;
  logic       btn_agachar;
  logic [2:0] heroe;
  logic [1:0] mov;
  logic       locked;
  logic       busy;

  modport master (
    output btn_next, btn_ok, btn_volar, btn_saltar, btn_agachar,
    input  heroe, mov, locked, busy
  );

  modport slave (
    input  btn_next, btn_ok, btn_volar, btn_saltar, btn_agachar,
    output heroe, mov, locked, busy
  );

endinterface
`default_nettype wire

// File: rtl/heroe_mov_ctrl_rise_detect.sv
`default_nettype none
// ============================================================================
// Module  : rise_detect
// Brief   : Registered sample plus rising-edge pulse for a vector of levels.
// Revision: 1.0 - initial release
// ============================================================================
module rise_detect #(
  parameter int WIDTH = 5
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] sig,
  output logic      [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] sig_q,  sig_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  always_comb begin
    sig_d  = sig;
    prev_d = sig_q;
  end

  // Both stages reset high so a button held through reset never fires
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q  <= '1;
      prev_q <= '1;
    end else begin
      sig_q  <= sig_d;
      prev_q <= prev_d;
    end
  end

  assign pulse = sig_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/heroe_mov_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : heroe_mov_ctrl
// Brief   : Hero selection and timed movement-glyph sequencer for the char ROM.
// Revision: 1.0 - initial release
// ============================================================================
module heroe_mov_ctrl
  import heroe_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input wire logic         clk,
  input wire logic         rst,
  heroe_mov_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [BTN_W-1:0] btn;
  logic [BTN_W-1:0] pulse;

  state_t           state_q,  state_d;
  logic [2:0]       heroe_q,  heroe_d;
  logic [1:0]       mov_q,    mov_d;
  logic             locked_q, locked_d;
  logic             busy_q,   busy_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  assign btn = {bus.btn_agachar, bus.btn_saltar, bus.btn_volar,
                bus.btn_ok, bus.btn_next};

  rise_detect #(.WIDTH(BTN_W)) u_rise (
    .clk   (clk),
    .rst   (rst),
    .sig   (btn),
    .pulse (pulse)
  );

  always_comb begin
    state_d  = state_q;
    heroe_d  = heroe_q;
    mov_d    = mov_q;
    locked_d = locked_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    case (state_q)
      SEL: begin
        if (pulse[BTN_OK]) begin
          state_d  = IDLE;
          locked_d = 1'b1;
        end else if (pulse[BTN_NEXT]) begin
          heroe_d = next_hero(heroe_q);
        end
      end
      IDLE: begin
        if (pulse[BTN_OK]) begin
          state_d  = SEL;
          locked_d = 1'b0;
        end else if (pulse[BTN_VOLAR] | pulse[BTN_SALTAR] | pulse[BTN_AGACHAR]) begin
          state_d = MOVE;
          busy_d  = 1'b1;
          cnt_d   = HOLD_LOAD;
          if (pulse[BTN_VOLAR])       mov_d = MOV_VOLAR;
          else if (pulse[BTN_SALTAR]) mov_d = MOV_SALTAR;
          else                        mov_d = MOV_AGACHAR;
        end
      end
      MOVE: begin
        // Buttons are deliberately ignored until the hold expires
        if (cnt_q == '0) begin
          state_d = IDLE;
          mov_d   = MOV_NONE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d  = SEL;
        mov_d    = MOV_NONE;
        locked_d = 1'b0;
        busy_d   = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEL;
      heroe_q  <= HERO_MIN;
      mov_q    <= MOV_NONE;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      heroe_q  <= heroe_d;
      mov_q    <= mov_d;
      locked_q <= locked_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.heroe  = heroe_q;
  assign bus.mov    = mov_q;
  assign bus.locked = locked_q;
  assign bus.busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_heroe_mov_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_heroe_mov_ctrl
// Brief   : Scoreboard bench for heroe_mov_ctrl against a cycle-level game model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_heroe_mov_ctrl;

  localparam int HOLD = 8;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_NEXT = 5'b00001;
  localparam logic [4:0] B_OK   = 5'b00010;
  localparam logic [4:0] B_VOL  = 5'b00100;
  localparam logic [4:0] B_SAL  = 5'b01000;
  localparam logic [4:0] B_AGA  = 5'b10000;

  typedef struct packed {
    logic [2:0] heroe;
    logic [1:0] mov;
    logic       locked;
    logic       busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  heroe_mov_ctrl_if bus();

  heroe_mov_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  obs_t exp_q[$];
  obs_t mon_exp, mon_act;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Game model: hero number, shown movement, phase flag, glyph cycles left
  int         m_heroe  = 1;
  int         m_mov    = 0;
  int         m_locked = 0;
  int         m_left   = 0;
  logic [4:0] seen1    = 5'b11111;
  logic [4:0] seen0    = 5'b11111;

  task automatic model_edge(input logic [4:0] p);
    if (m_locked == 0) begin
      if (p[1])      m_locked = 1;
      else if (p[0]) m_heroe  = (m_heroe == 5) ? 1 : m_heroe + 1;
    end else if (m_mov == 0) begin
      if (p[1]) m_locked = 0;
      else if (p[2] || p[3] || p[4]) begin
        m_mov  = p[2] ? 1 : (p[3] ? 2 : 3);
        m_left = HOLD;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) m_mov = 0;
    end
  endtask

  // One clock: drive levels, advance the model across the coming edge
  task automatic step(input logic r, input logic [4:0] b);
    obs_t e;
    rst             = r;
    bus.btn_next    = b[0];
    bus.btn_ok      = b[1];
    bus.btn_volar   = b[2];
    bus.btn_saltar  = b[3];
    bus.btn_agachar = b[4];
    if (r) begin
      m_heroe = 1; m_mov = 0; m_locked = 0; m_left = 0;
      seen1 = 5'b11111; seen0 = 5'b11111;
    end else begin
      // a level takes effect one edge after it is first sampled
      model_edge(seen1 & ~seen0);
      seen0 = seen1;
      seen1 = b;
    end
    e.heroe  = 3'(m_heroe);
    e.mov    = 2'(m_mov);
    e.locked = (m_locked != 0);
    e.busy   = (m_mov != 0);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic press(input logic [4:0] b);
    step(1'b0, b);
    step(1'b0, B_NONE);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, B_NONE);
  endtask

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {bus.heroe, bus.mov, bus.locked, bus.busy};
      checks  = checks + 1;
      if (mon_act !== mon_exp) begin
        failures = failures + 1;
        $display("FAIL outputs cyc=%0d got heroe=%0d mov=%0d locked=%b busy=%b want heroe=%0d mov=%0d locked=%b busy=%b",
                 cyc, mon_act.heroe, mon_act.mov, mon_act.locked, mon_act.busy,
                 mon_exp.heroe, mon_exp.mov, mon_exp.locked, mon_exp.busy);
      end
    end
  end

  logic [4:0] rb;

  initial begin
    step(1'b1, B_NONE);
    step(1'b1, B_NONE);
    idle(3);
    // Hero cycling, wrap, and a long hold that must advance once
    press(B_NEXT); press(B_NEXT); press(B_NEXT);
    press(B_NEXT); press(B_NEXT);
    repeat (100) step(1'b0, B_NEXT);
    idle(2);
    // Confirm, then one saltar hold
    press(B_OK);
    press(B_SAL);
    idle(12);
    // Simultaneous movements, then a press during the hold
    press(B_VOL | B_SAL | B_AGA);
    idle(2);
    press(B_SAL);
    idle(10);
    // ok beats a movement in IDLE
    press(B_OK | B_AGA);
    idle(3);
    // Reset mid-hold with volar held through and after it
    press(B_OK);
    press(B_VOL);
    idle(2);
    step(1'b1, B_VOL);
    step(1'b1, B_VOL);
    repeat (3) step(1'b0, B_VOL);
    step(1'b0, B_VOL | B_OK);
    repeat (10) step(1'b0, B_VOL);
    idle(1);
    press(B_VOL);
    idle(12);
    // Randomised play with sticky levels and rare resets
    rb = B_NONE;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        rb = 5'($urandom) & 5'($urandom);
        if ($urandom_range(0, 2) != 0) rb = B_NONE;
      end
      step(($urandom_range(0, 299) == 0), rb);
    end
    idle(4);
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain got pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/heroe_mov_ctrl.md
# heroe_mov_ctrl

Sequencer that drives the `heroe`/`mov` select inputs of the character ROM from the player's push-buttons. In the selection phase the player cycles through heroes 1–5 and confirms one. In the play phase each movement request shows the movement glyph for a fixed hold time, then the display returns to the hero glyph. The block sits between the debounced button inputs and the character ROM, in the display path of the game top level.

## Interface
- `HOLD_CYCLES`, default 50_000_000: cycles a movement glyph stays on the display (1 s at 50 MHz). Legal range is ≥ 1.
- `CNT_W`, default 26: hold-counter width. Must satisfy 2^CNT_W > HOLD_CYCLES−1.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_next` in 1: advance hero selection. Debounced level, synchronous to `clk`.
- `btn_ok` in 1: confirm hero / return to selection. Debounced level.
- `btn_volar` in 1: request fly movement. Debounced level.
- `btn_saltar` in 1: request jump movement. Debounced level.
- `btn_agachar` in 1: request crouch movement. Debounced level.
- `heroe` out 3: hero code to the ROM, range 1..5. Registered.
- `mov` out 2: movement code to the ROM. 0 = hero glyph, 1 = volar, 2 = saltar, 3 = agachar. Registered.
- `locked` out 1: a hero is confirmed (play phase). Registered.
- `busy` out 1: a movement hold is in progress. Registered.

## Operation
- All buttons go through rising-edge detection: `pulse = btn & ~btn_prev`.
  - The `btn_prev` registers reset to 1, so a button held through reset does not fire.
  - A held button fires once only.
- Reset values: state = SEL, `heroe` = 1, `mov` = 0, `locked` = 0, `busy` = 0, counter = 0.
- States and transitions:
  - **SEL** (`locked` = 0, `mov` = 0)
    - `next` pulse: `heroe` increments 1→2→3→4→5→1. It wraps from 5 to 1 and never takes the values 0, 6 or 7.
    - `ok` pulse: go to IDLE and set `locked` = 1.
    - If `next` and `ok` pulse in the same cycle, `ok` wins and `heroe` is unchanged.
    - Movement pulses are ignored.
  - **IDLE** (`locked` = 1, `mov` = 0, `busy` = 0)
    - Movement pulse: go to MOVE, set `mov` to the movement code, set `busy` = 1, load counter with HOLD_CYCLES−1.
    - If several movement pulses arrive in the same cycle, priority is volar > saltar > agachar.
    - `ok` pulse: go to SEL, set `locked` = 0, `heroe` holds its value.
    - If `ok` and a movement pulse arrive together, `ok` wins.
    - `next` is ignored.
  - **MOVE** (`busy` = 1)
    - Counter decrements each cycle.
    - When the counter reads 0: go to IDLE, set `mov` = 0, `busy` = 0.
    - All button pulses are ignored: no queuing, no retrigger, no cancel.
- `heroe` changes only in SEL.
- `mov` ≠ 0 only in MOVE.
- `rst` asserted in any state, including mid-hold, restores the reset values on the next edge.

## Timing
- Pulse latency: button sampled high at edge t (low at t−1) → pulse during cycle t → outputs updated at edge t+1. Total latency is one cycle from the first high sample.
- Hold length: `mov` is nonzero for exactly HOLD_CYCLES consecutive cycles.
- With HOLD_CYCLES = 1 the glyph lasts one cycle, and IDLE follows immediately.
- Earliest re-trigger: a movement pulse can start a new hold on the first IDLE cycle, giving a one-cycle `mov` = 0 gap between holds.
- Counter arithmetic is unsigned CNT_W bits and is never decremented below 0.

## Structure
- Shared package `heroe_pkg` holds:
  - hero constants: HERO_MIN = 1, HERO_MAX = 5;
  - movement codes: MOV_NONE = 0, MOV_VOLAR = 1, MOV_SALTAR = 2, MOV_AGACHAR = 3;
  - the state enum {SEL, IDLE, MOVE}.
  - The ROM and this block both use the package.
- Sub-module: `rise_detect`, parameterised by width and instantiated once at width 5 for all buttons.
- Everything else lives in `heroe_mov_ctrl`: the state register, hero counter and hold counter.

## Test plan
- Reset, then three `next` presses → `heroe` reads 2, 3, 4, each one cycle after its press. `mov` stays 0 and `locked` stays 0.
- From `heroe` = 5, a `next` press → `heroe` = 1. A `btn_next` held high for 100 cycles advances `heroe` only once.
- `ok` press, then `saltar` press (HOLD_CYCLES = 8):
  - `locked` = 1;
  - `mov` = 2 and `busy` = 1 for exactly 8 cycles, then `mov` = 0 and `busy` = 0.
- In IDLE, `volar`, `saltar` and `agachar` pressed in the same cycle → `mov` = 1. A `saltar` press during the hold leaves `mov` = 1 and the hold length unchanged.
- `ok` and `agachar` pressed together in IDLE → state SEL, `locked` = 0, `mov` = 0, `heroe` unchanged.
- `rst` pulsed mid-hold, with `btn_volar` held high through and after reset → all outputs at reset values, and no movement fires until `btn_volar` is released and pressed again.
